// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_ctrl
// Purpose  : Arbitrates decode-stage control-flow changes (JR, J/JAL, taken
//            BEQ/BNE) into PC redirect enables. A redirect seen while fetch
//            cannot advance is parked in hold registers and committed on the
//            first cycle that fetch advances. HALT freezes the PC until reset.
// Ports    : CLK, nRST                  clock / async active-low reset
//            ihit, stall, halt          fetch done, downstream stall, HALT
//            valid_d, op_*              decode-stage control
//            rs_data, rt_data, imm16,
//            jimm, pc_add4_d            operands for targets and compare
//            pc_enable, *_enable        PC update strobes
//            jr_addr, bra_addr, j_addr  redirect targets
//            flush_fd                   squash fetch/decode register
//            halted, redirect_cnt       status
// Revision : 1.0  initial release
// ============================================================================
module pc_redirect_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        halt,
  input  logic        valid_d,
  input  logic        op_beq,
  input  logic        op_bne,
  input  logic        op_j,
  input  logic        op_jr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm16,
  input  logic [25:0] jimm,
  input  logic [31:0] pc_add4_d,
  output logic        pc_enable,
  output logic        jr_enable,
  output logic        bra_enable,
  output logic        j_enable,
  output logic [31:0] jr_addr,
  output logic [31:0] bra_addr,
  output logic [25:0] j_addr,
  output logic        flush_fd,
  output logic        halted,
  output logic [15:0] redirect_cnt
);

  localparam logic [1:0] c_RUN  = 2'd0;
  localparam logic [1:0] c_HOLD = 2'd1;
  localparam logic [1:0] c_HALT = 2'd2;

  // redirect kind encoding
  localparam logic [1:0] c_K_NONE = 2'd0;
  localparam logic [1:0] c_K_JR   = 2'd1;
  localparam logic [1:0] c_K_J    = 2'd2;
  localparam logic [1:0] c_K_BRA  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [1:0]  r_hold_kind;
  logic [31:0] r_hold_target;
  logic [15:0] r_cnt;

  logic        w_adv;
  logic        w_taken;
  logic [31:0] w_bra_target;
  logic [1:0]  w_req_kind;
  logic [31:0] w_req_target;

  logic        w_pc_en, w_jr_en, w_bra_en, w_j_en, w_flush, w_halted;
  logic [31:0] w_jr_addr, w_bra_addr;
  logic [25:0] w_j_addr;

  assign w_adv        = ihit & ~stall;
  assign w_taken      = (op_beq & (rs_data == rt_data)) | (op_bne & (rs_data != rt_data));
  assign w_bra_target = pc_add4_d + {{14{imm16[15]}}, imm16, 2'b00};

  // request selection: JR beats J beats taken branch
  always_comb begin
    w_req_kind   = c_K_NONE;
    w_req_target = 32'd0;
    if (valid_d) begin
      if (op_jr) begin
        w_req_kind   = c_K_JR;
        w_req_target = rs_data;
      end else if (op_j) begin
        w_req_kind   = c_K_J;
        w_req_target = {6'd0, jimm};
      end else if (w_taken) begin
        w_req_kind   = c_K_BRA;
        w_req_target = w_bra_target;
      end
    end
  end

  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= c_RUN;
    else       r_state <= w_next_state;
  end

  // next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_RUN: begin
        if (halt)                                  w_next_state = c_HALT;
        else if (w_req_kind != c_K_NONE && !w_adv) w_next_state = c_HOLD;
      end
      c_HOLD: begin
        if (halt)       w_next_state = c_HALT;
        else if (w_adv) w_next_state = c_RUN;
      end
      c_HALT:  w_next_state = c_HALT;
      default: w_next_state = c_RUN;
    endcase
  end

  // hold registers: capture only when a request cannot commit this cycle
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hold_kind   <= c_K_NONE;
      r_hold_target <= 32'd0;
    end else if (r_state == c_RUN && !halt && w_req_kind != c_K_NONE && !w_adv) begin
      r_hold_kind   <= w_req_kind;
      r_hold_target <= w_req_target;
    end
  end

  // output logic
  always_comb begin
    w_pc_en    = 1'b0;
    w_jr_en    = 1'b0;
    w_bra_en   = 1'b0;
    w_j_en     = 1'b0;
    w_flush    = 1'b0;
    w_halted   = 1'b0;
    w_jr_addr  = 32'd0;
    w_bra_addr = 32'd0;
    w_j_addr   = 26'd0;
    case (r_state)
      c_RUN: begin
        w_jr_addr  = rs_data;
        w_bra_addr = w_bra_target;
        w_j_addr   = jimm;
        if (!halt) begin
          if (w_req_kind == c_K_NONE) begin
            w_pc_en = w_adv;
          end else if (w_adv) begin
            w_pc_en  = 1'b1;
            w_flush  = 1'b1;
            w_jr_en  = (w_req_kind == c_K_JR);
            w_j_en   = (w_req_kind == c_K_J);
            w_bra_en = (w_req_kind == c_K_BRA);
          end
        end
      end
      c_HOLD: begin
        // decode inputs are stale here; only the captured redirect is driven
        w_jr_addr  = (r_hold_kind == c_K_JR)  ? r_hold_target : 32'd0;
        w_bra_addr = (r_hold_kind == c_K_BRA) ? r_hold_target : 32'd0;
        w_j_addr   = (r_hold_kind == c_K_J)   ? r_hold_target[25:0] : 26'd0;
        if (!halt) begin
          w_jr_en  = (r_hold_kind == c_K_JR);
          w_j_en   = (r_hold_kind == c_K_J);
          w_bra_en = (r_hold_kind == c_K_BRA);
          w_pc_en  = w_adv;
          w_flush  = w_adv;
        end
      end
      c_HALT:  w_halted = 1'b1;
      default: w_halted = 1'b0;
    endcase
  end

  // committed-redirect counter, saturating
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= 16'd0;
    end else if (w_pc_en && (w_jr_en || w_bra_en || w_j_en) && r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // every output is forced low the moment reset asserts
  assign pc_enable    = nRST & w_pc_en;
  assign jr_enable    = nRST & w_jr_en;
  assign bra_enable   = nRST & w_bra_en;
  assign j_enable     = nRST & w_j_en;
  assign flush_fd     = nRST & w_flush;
  assign halted       = nRST & w_halted;
  assign jr_addr      = nRST ? w_jr_addr  : 32'd0;
  assign bra_addr     = nRST ? w_bra_addr : 32'd0;
  assign j_addr       = nRST ? w_j_addr   : 26'd0;
  assign redirect_cnt = nRST ? r_cnt      : 16'd0;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_redirect_ctrl
// Purpose  : Self-checking bench for pc_redirect_ctrl: vector table for
//            single-cycle RUN behaviour, directed multi-cycle sequences, and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_redirect_ctrl;

  logic        CLK, nRST;
  logic        ihit, stall, halt, valid_d;
  logic        op_beq, op_bne, op_j, op_jr;
  logic [31:0] rs_data, rt_data, pc_add4_d;
  logic [15:0] imm16;
  logic [25:0] jimm;
  logic        pc_enable, jr_enable, bra_enable, j_enable, flush_fd, halted;
  logic [31:0] jr_addr, bra_addr;
  logic [25:0] j_addr;
  logic [15:0] redirect_cnt;

  int checks = 0;
  int errors = 0;

  pc_redirect_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .halt(halt),
    .valid_d(valid_d), .op_beq(op_beq), .op_bne(op_bne), .op_j(op_j),
    .op_jr(op_jr), .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
    .jimm(jimm), .pc_add4_d(pc_add4_d), .pc_enable(pc_enable),
    .jr_enable(jr_enable), .bra_enable(bra_enable), .j_enable(j_enable),
    .jr_addr(jr_addr), .bra_addr(bra_addr), .j_addr(j_addr),
    .flush_fd(flush_fd), .halted(halted), .redirect_cnt(redirect_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; stall = 1'b0; halt = 1'b0; valid_d = 1'b0;
    op_beq = 1'b0; op_bne = 1'b0; op_j = 1'b0; op_jr = 1'b0;
    rs_data = 32'd0; rt_data = 32'd0; pc_add4_d = 32'd0; imm16 = 16'd0; jimm = 26'd0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    idle();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid, beq, bne, j, jr, ih, st;
    logic [31:0] rs, rt, pc4;
    logic [15:0] imm;
    logic [25:0] ji;
    logic        e_pc, e_jr, e_bra, e_j, e_fl;
    logic [31:0] e_braa;
  } vec_t;

  vec_t vt[10];

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  kind;   // 1 jr, 2 j, 3 bra
    logic [31:0] target;
  } pend_t;

  pend_t pend_q[$];
  bit    m_halted;
  int    m_cnt;

  typedef struct {
    logic        pc, jr, bra, j, fl, hl;
    logic [31:0] jra, braa, ja;
    logic [2:0]  amask;  // which addresses are defined: {j, bra, jr}
  } exp_t;

  task automatic model_reset();
    pend_q.delete();
    m_halted = 0;
    m_cnt    = 0;
  endtask

  // Evaluates one cycle from the current inputs and advances the model past
  // the next rising edge.
  task automatic model_step(output exp_t e);
    bit adv;
    bit taken;
    int kind;
    logic [31:0] bt;
    pend_t p;
    adv   = ihit && !stall;
    taken = (op_beq && rs_data == rt_data) || (op_bne && rs_data != rt_data);
    bt    = pc_add4_d + (32'($signed(imm16)) * 4);
    e     = '{default: '0};
    e.amask = 3'b111;
    if (m_halted) begin
      e.hl = 1'b1;
    end else if (pend_q.size() > 0) begin
      p = pend_q[0];
      e.amask = (p.kind == 2'd1) ? 3'b001 : (p.kind == 2'd3) ? 3'b010 : 3'b100;
      e.jra   = p.target;
      e.braa  = p.target;
      e.ja    = p.target;
      if (halt) begin
        m_halted = 1;
        pend_q.delete();
      end else begin
        e.jr  = (p.kind == 2'd1);
        e.j   = (p.kind == 2'd2);
        e.bra = (p.kind == 2'd3);
        e.pc  = adv;
        e.fl  = adv;
        if (adv) void'(pend_q.pop_front());
      end
    end else begin
      e.jra  = rs_data;
      e.braa = bt;
      e.ja   = {6'd0, jimm};
      kind = 0;
      if (valid_d) kind = op_jr ? 1 : op_j ? 2 : taken ? 3 : 0;
      if (halt) begin
        m_halted = 1;
      end else if (kind == 0) begin
        e.pc = adv;
      end else if (adv) begin
        e.pc = 1; e.fl = 1;
        e.jr = (kind == 1); e.j = (kind == 2); e.bra = (kind == 3);
      end else begin
        p.kind   = 2'(kind);
        p.target = (kind == 1) ? rs_data : (kind == 2) ? {6'd0, jimm} : bt;
        pend_q.push_back(p);
      end
    end
    if (e.pc && (e.jr || e.bra || e.j) && m_cnt < 65535) m_cnt++;
  endtask

  task automatic compare(input string tag, input exp_t e, input int cnt_before);
    check({tag, ".pc_enable"},  32'(pc_enable),  32'(e.pc));
    check({tag, ".jr_enable"},  32'(jr_enable),  32'(e.jr));
    check({tag, ".bra_enable"}, 32'(bra_enable), 32'(e.bra));
    check({tag, ".j_enable"},   32'(j_enable),   32'(e.j));
    check({tag, ".flush_fd"},   32'(flush_fd),   32'(e.fl));
    check({tag, ".halted"},     32'(halted),     32'(e.hl));
    check({tag, ".cnt"},        32'(redirect_cnt), 32'(cnt_before));
    if (e.amask[0]) check({tag, ".jr_addr"},  jr_addr,  e.jra);
    if (e.amask[1]) check({tag, ".bra_addr"}, bra_addr, e.braa);
    if (e.amask[2]) check({tag, ".j_addr"},   32'(j_addr), 32'(e.ja[25:0]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pc_enable"},  32'(pc_enable),  32'd0);
    check({tag, ".jr_enable"},  32'(jr_enable),  32'd0);
    check({tag, ".bra_enable"}, 32'(bra_enable), 32'd0);
    check({tag, ".j_enable"},   32'(j_enable),   32'd0);
    check({tag, ".flush_fd"},   32'(flush_fd),   32'd0);
    check({tag, ".halted"},     32'(halted),     32'd0);
    check({tag, ".jr_addr"},    jr_addr,         32'd0);
    check({tag, ".bra_addr"},   bra_addr,        32'd0);
    check({tag, ".j_addr"},     32'(j_addr),     32'd0);
    check({tag, ".cnt"},        32'(redirect_cnt), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   cb;
    bit   rst_now;

    //            valid beq bne j jr ih st  rs          rt          pc4           imm       ji          pc jr br j fl bra_addr
    vt[0] = '{1, 1, 0, 0, 0, 1, 0, 32'd5,     32'd5,      32'h100,      16'hFFFE, 26'h0,      1, 0, 1, 0, 1, 32'hF8};
    vt[1] = '{1, 0, 1, 0, 0, 1, 0, 32'd7,     32'd7,      32'h200,      16'h0004, 26'h0,      1, 0, 0, 0, 0, 32'h210};
    vt[2] = '{1, 1, 0, 1, 1, 1, 0, 32'd3,     32'd3,      32'h40,       16'h0000, 26'h155,    1, 1, 0, 0, 1, 32'h40};
    vt[3] = '{1, 0, 0, 1, 0, 1, 0, 32'h11,    32'h22,     32'h1000,     16'h0010, 26'h3ABCDEF,1, 0, 0, 1, 1, 32'h1040};
    vt[4] = '{1, 0, 1, 0, 0, 1, 0, 32'd1,     32'd2,      32'h2000,     16'h7FFF, 26'h0,      1, 0, 1, 0, 1, 32'h21FFC};
    vt[5] = '{1, 1, 0, 0, 0, 1, 0, 32'd1,     32'd2,      32'h10,       16'h0001, 26'h0,      1, 0, 0, 0, 0, 32'h14};
    vt[6] = '{0, 0, 0, 0, 1, 1, 0, 32'h999,   32'd0,      32'h30,       16'h0000, 26'h0,      1, 0, 0, 0, 0, 32'h30};
    vt[7] = '{1, 1, 0, 0, 0, 1, 1, 32'd1,     32'd2,      32'h50,       16'hFFFF, 26'h0,      0, 0, 0, 0, 0, 32'h4C};
    vt[8] = '{1, 1, 0, 0, 0, 1, 0, 32'hABCD,  32'hABCD,   32'hFFFFFFFC, 16'h0001, 26'h0,      1, 0, 1, 0, 1, 32'h0};
    vt[9] = '{0, 0, 0, 0, 0, 0, 0, 32'd0,     32'd0,      32'h60,       16'h0000, 26'h0,      0, 0, 0, 0, 0, 32'h60};

    nRST = 1'b0;
    idle();
    #2;
    check_all_zero("reset");
    do_reset();

    // ---- table: every vector keeps the block in RUN ----
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      idle();
      valid_d = vt[i].valid; op_beq = vt[i].beq; op_bne = vt[i].bne;
      op_j = vt[i].j; op_jr = vt[i].jr; ihit = vt[i].ih; stall = vt[i].st;
      rs_data = vt[i].rs; rt_data = vt[i].rt; pc_add4_d = vt[i].pc4;
      imm16 = vt[i].imm; jimm = vt[i].ji;
      #2;
      check($sformatf("vec%0d.pc_enable", i),  32'(pc_enable),  32'(vt[i].e_pc));
      check($sformatf("vec%0d.jr_enable", i),  32'(jr_enable),  32'(vt[i].e_jr));
      check($sformatf("vec%0d.bra_enable", i), 32'(bra_enable), 32'(vt[i].e_bra));
      check($sformatf("vec%0d.j_enable", i),   32'(j_enable),   32'(vt[i].e_j));
      check($sformatf("vec%0d.flush_fd", i),   32'(flush_fd),   32'(vt[i].e_fl));
      check($sformatf("vec%0d.bra_addr", i),   bra_addr,        vt[i].e_braa);
      check($sformatf("vec%0d.jr_addr", i),    jr_addr,         vt[i].rs);
      check($sformatf("vec%0d.j_addr", i),     32'(j_addr),     32'(vt[i].ji));
      if (i == 0) begin
        @(negedge CLK);
        idle();
        #2;
        check("taken_branch.cnt_after_edge", 32'(redirect_cnt), 32'd1);
      end
    end

    // ---- held JR: capture cycle, two waiting cycles, commit ----
    do_reset();
    @(negedge CLK);
    valid_d = 1; op_jr = 1; rs_data = 32'h400; ihit = 0;
    #2;
    check("hold.c1.jr_enable", 32'(jr_enable), 32'd0);
    check("hold.c1.jr_addr",   jr_addr,        32'h400);
    check("hold.c1.pc_enable", 32'(pc_enable), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge CLK);
      rs_data = 32'h800;
      op_jr   = 1'b0;
      ihit    = (c == 4);
      #2;
      check($sformatf("hold.c%0d.jr_enable", c), 32'(jr_enable), 32'd1);
      check($sformatf("hold.c%0d.jr_addr", c),   jr_addr,        32'h400);
      check($sformatf("hold.c%0d.pc_enable", c), 32'(pc_enable), 32'(c == 4));
      check($sformatf("hold.c%0d.flush_fd", c),  32'(flush_fd),  32'(c == 4));
    end
    @(negedge CLK);
    idle();
    #2;
    check("hold.after.jr_enable", 32'(jr_enable), 32'd0);
    check("hold.after.cnt",       32'(redirect_cnt), 32'd1);

    // ---- halt overrides a taken branch ----
    do_reset();
    @(negedge CLK);
    valid_d = 1; op_beq = 1; rs_data = 9; rt_data = 9; pc_add4_d = 32'h80; halt = 1;
    #2;
    check("halt.c0.pc_enable",  32'(pc_enable),  32'd0);
    check("halt.c0.bra_enable", 32'(bra_enable), 32'd0);
    check("halt.c0.halted",     32'(halted),     32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      halt = 0; op_beq = 0; op_jr = 1; ihit = 1;
      #2;
      check($sformatf("halt.c%0d.pc_enable", c), 32'(pc_enable), 32'd0);
      check($sformatf("halt.c%0d.jr_enable", c), 32'(jr_enable), 32'd0);
      check($sformatf("halt.c%0d.halted", c),    32'(halted),    32'd1);
      check($sformatf("halt.c%0d.jr_addr", c),   jr_addr,        32'd0);
    end

    // ---- counter saturation, then reset in the middle of HOLD ----
    do_reset();
    for (int n = 0; n < 65535; n++) begin
      @(negedge CLK);
      valid_d = 1; op_j = 1; jimm = 26'(n); ihit = 1;
    end
    @(negedge CLK);
    #2;
    check("sat.cnt_at_max", 32'(redirect_cnt), 32'hFFFF);
    check("sat.extra.j_enable", 32'(j_enable), 32'd1);
    @(negedge CLK);
    op_j = 0; op_jr = 1; rs_data = 32'hCAFE0; ihit = 0;
    #2;
    check("sat.cnt_stays", 32'(redirect_cnt), 32'hFFFF);
    @(negedge CLK);
    op_jr = 0;
    #2;
    check("sat.hold.jr_enable", 32'(jr_enable), 32'd1);
    nRST = 1'b0;
    #1;
    check_all_zero("rst_in_hold");
    @(negedge CLK);
    nRST = 1'b1;
    idle();
    #2;
    check("post_rst.jr_enable", 32'(jr_enable), 32'd0);
    check("post_rst.pc_enable", 32'(pc_enable), 32'd1);
    check("post_rst.cnt",       32'(redirect_cnt), 32'd0);

    // ---- randomized traffic against the reference model ----
    do_reset();
    model_reset();
    for (int it = 0; it < 3000; it++) begin
      @(negedge CLK);
      if (!nRST) nRST = 1'b1;
      valid_d = ($urandom_range(0, 3) != 0);
      op_jr   = ($urandom_range(0, 5) == 0);
      op_j    = ($urandom_range(0, 5) == 0);
      op_beq  = ($urandom_range(0, 2) == 0);
      op_bne  = ($urandom_range(0, 2) == 0);
      rs_data = $urandom;
      rt_data = ($urandom_range(0, 1) != 0) ? rs_data : $urandom;
      imm16   = 16'($urandom);
      jimm    = 26'($urandom);
      pc_add4_d = $urandom;
      ihit    = ($urandom_range(0, 2) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      halt    = ($urandom_range(0, 150) == 0);
      rst_now = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 80) == 0);
      if (rst_now) begin
        nRST = 1'b0;
        #2;
        check_all_zero($sformatf("rnd%0d.rst", it));
        model_reset();
      end else begin
        #2;
        cb = m_cnt;
        model_step(e);
        compare($sformatf("rnd%0d", it), e, cb);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
